div_unit: RTL and testbench

Iterative 32-bit integer divider implementing the RV32M DIV, DIVU, REM and REMU instructions. It is the multi-cycle partner to the single-cycle combinational ALU. The execute stage hands it operands with a start pulse, holds the pipeline while busy, and takes the quotient or remainder back on a one-cycle valid pulse with the destination register tag. It uses a radix-2 restoring algorithm: one quotient bit per clock, with RISC-V corner cases resolved in one cycle.

---
 rtl/div_unit.sv | 86 ++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring RV32M DIV/DIVU/REM/REMU divider, one quotient bit per clock
module div_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_rem, r_quot, r_div;
  logic r_neg_q, r_neg_r, r_is_rem;
  logic [REG_ADDR_WIDTH-1:0] r_tag;
  logic w_accept, w_signed, w_zero, w_ovf, w_special;
  logic [DATA_WIDTH-1:0] w_abs_a, w_abs_b, w_special_res, w_res;
  logic [DATA_WIDTH:0] w_shift, w_diff;
  assign busy_o = r_state == CALC || r_state == FIX;
  assign valid_o = r_state == DONE;
  assign w_accept = start_i && !busy_o && !flush_i;
  assign w_signed = !op_i[0];
  assign w_abs_a = (w_signed && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
  assign w_abs_b = (w_signed && divisor_i[DATA_WIDTH-1]) ? -divisor_i : divisor_i;
  assign w_zero = divisor_i == '0;
  assign w_ovf = w_signed && dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}} && &divisor_i;
  assign w_special = w_zero || w_ovf;
  assign w_special_res = w_zero ? (op_i[1] ? dividend_i : '1) : (op_i[1] ? '0 : dividend_i);
  assign w_shift = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_diff = w_shift - {1'b0, r_div};
  assign w_res = r_is_rem ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quot : r_quot);
  always_comb begin
    w_next = flush_i ? IDLE :
             w_accept ? (w_special ? DONE : CALC) :
             r_state == CALC ? (&r_cnt ? FIX : CALC) :
             r_state == FIX ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quot <= '0;
      r_div <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_is_rem <= 1'b0;
      r_tag <= '0;
      result_o <= '0;
      rd_addr_o <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quot <= w_abs_a;
      r_div <= w_abs_b;
      r_neg_q <= w_signed && (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
      r_neg_r <= w_signed && dividend_i[DATA_WIDTH-1];
      r_is_rem <= op_i[1];
      r_tag <= rd_addr_i;
      if (w_special) begin
        result_o <= w_special_res;
        rd_addr_o <= rd_addr_i;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
      r_quot <= {r_quot[DATA_WIDTH-2:0], !w_diff[DATA_WIDTH]};
    end else if (r_state == FIX && !flush_i) begin
      result_o <= w_res;
      rd_addr_o <= r_tag;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table, random and corner-sequence checks of div_unit against an arithmetic model
module tb_div_unit;
  logic clk = 0;
  logic rst = 1;
  logic start_i = 0;
  logic [1:0] op_i = 0;
  logic [31:0] dividend_i = 0;
  logic [31:0] divisor_i = 0;
  logic [4:0] rd_addr_i = 0;
  logic flush_i = 0;
  logic busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0] rd_addr_o;
  int n_pass = 0;
  int n_total = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] tag;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[14];
  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o),
    .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hffffffff;
    if (!op[0]) begin
      if (a == 32'h80000000 && b == 32'hffffffff) return op[1] ? 32'h0 : 32'h80000000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int junk_at, input string nm);
    int lat, exp_lat;
    logic busy_bad;
    exp_lat = (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hffffffff)) ? 1 : 34;
    @(negedge clk);
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = tag;
    @(posedge clk);
    #1 start_i = 0; op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom; rd_addr_i = 5'($urandom);
    lat = 0;
    busy_bad = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      start_i = (n == junk_at);
      if (busy_o !== (n < exp_lat)) busy_bad = 1;
      if (valid_o) lat = n;
    end
    start_i = 0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, result_o, exp);
    chk({nm, " tag"}, {27'b0, rd_addr_o}, {27'b0, tag});
    chk({nm, " busy profile"}, {31'b0, busy_bad}, 32'b0);
    @(negedge clk);
    chk({nm, " pulse end"}, {31'b0, valid_o}, 32'b0);
    chk({nm, " result hold"}, result_o, exp);
  endtask
  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    logic [4:0] rtag;
    logic seen;
    int lat;
    tv = '{
      '{2'b01, 32'd100, 32'd7, 5'd5, 32'd14},
      '{2'b11, 32'd100, 32'd7, 5'd6, 32'd2},
      '{2'b00, 32'hfffffff9, 32'd2, 5'd7, 32'hfffffffd},
      '{2'b10, 32'hfffffff9, 32'd2, 5'd8, 32'hffffffff},
      '{2'b10, 32'd7, 32'hfffffffe, 5'd9, 32'd1},
      '{2'b01, 32'd5, 32'd0, 5'd10, 32'hffffffff},
      '{2'b10, 32'd5, 32'd0, 5'd11, 32'd5},
      '{2'b00, 32'h80000000, 32'hffffffff, 5'd12, 32'h80000000},
      '{2'b10, 32'h80000000, 32'hffffffff, 5'd13, 32'd0},
      '{2'b01, 32'h80000000, 32'hffffffff, 5'd14, 32'd0},
      '{2'b00, 32'h80000000, 32'd1, 5'd15, 32'h80000000},
      '{2'b10, 32'hfffffff9, 32'hfffffffe, 5'd16, 32'hffffffff},
      '{2'b01, 32'hffffffff, 32'd1, 5'd17, 32'hffffffff},
      '{2'b11, 32'hffffffff, 32'hffffffff, 5'd31, 32'd0}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy_o}, 32'b0);
    chk("reset valid", {31'b0, valid_o}, 32'b0);
    chk("reset result", result_o, 32'b0);
    chk("reset tag", {27'b0, rd_addr_o}, 32'b0);
    rst = 0;
    for (int i = 0; i < 14; i++) run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].tag, tv[i].exp, 0, $sformatf("vec%0d", i));
    run_op(2'b01, 32'd1000, 32'd7, 5'd3, 32'd142, 5, "ignored start");
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      ra = pick();
      rb = pick();
      rtag = 5'($urandom);
      run_op(rop, ra, rb, rtag, model(rop, ra, rb), 0, $sformatf("rnd%0d op%0d %h/%h", i, rop, ra, rb));
    end
    @(negedge clk);
    start_i = 1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd4;
    @(posedge clk);
    #1 start_i = 0;
    seen = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start_i = (n == 4);
      op_i = 2'b11; dividend_i = 32'd50; divisor_i = 32'd9; rd_addr_i = 5'd20;
      if (valid_o || !busy_o) seen = 1;
      flush_i = (n == 9);
    end
    @(negedge clk);
    start_i = 0;
    flush_i = 0;
    chk("busy while calc", {31'b0, seen}, 32'b0);
    chk("flush busy drop", {31'b0, busy_o}, 32'b0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid_o || busy_o) seen = 1;
    end
    chk("flush no valid", {31'b0, seen}, 32'b0);
    run_op(2'b01, 32'd1000, 32'd3, 5'd4, 32'd333, 0, "after flush");
    @(negedge clk);
    start_i = 1; flush_i = 1; op_i = 2'b01; dividend_i = 32'd5; divisor_i = 32'd0;
    @(negedge clk);
    start_i = 0; flush_i = 0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid_o || busy_o) seen = 1;
      @(negedge clk);
    end
    chk("start with flush dropped", {31'b0, seen}, 32'b0);
    start_i = 1; op_i = 2'b01; dividend_i = 32'd12345; divisor_i = 32'd7; rd_addr_i = 5'd9;
    @(negedge clk);
    start_i = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst busy", {31'b0, busy_o}, 32'b0);
    chk("rst valid", {31'b0, valid_o}, 32'b0);
    chk("rst result", result_o, 32'b0);
    chk("rst tag", {27'b0, rd_addr_o}, 32'b0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid_o || busy_o) seen = 1;
    end
    chk("rst no valid", {31'b0, seen}, 32'b0);
    start_i = 1; op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = 5'd1;
    @(posedge clk);
    #1 start_i = 0;
    lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (valid_o) lat = n;
    end
    chk("b2b first latency", lat, 34);
    chk("b2b first result", result_o, 32'd3);
    chk("b2b first tag", {27'b0, rd_addr_o}, 32'd1);
    start_i = 1; op_i = 2'b11; dividend_i = 32'd9; divisor_i = 32'd4; rd_addr_i = 5'd2;
    @(posedge clk);
    #1 start_i = 0;
    lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (valid_o) lat = n;
    end
    chk("b2b second latency", lat, 34);
    chk("b2b second result", result_o, 32'd1);
    chk("b2b second tag", {27'b0, rd_addr_o}, 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
